// File: rtl/bch_chien_ctrl_if.sv
// rtl/bch_chien_ctrl_if.sv - solver/datapath/correction-stage signals of the Chien search controller
interface bch_chien_ctrl_if #(
    parameter int BITS = 4,
    parameter int CW   = 4
) ();
    logic            sigma_valid;
    logic            sigma_ready;
    logic [CW-1:0]   err_count;
    logic            chien_start;
    logic            chien_first;
    logic [BITS-1:0] err_bits;
    logic            out_valid;
    logic            out_first;
    logic            out_last;
    logic [BITS-1:0] out_err;
    logic            done;
    logic            fail;
    logic [CW-1:0]   root_count;

    modport master (
        output sigma_valid, err_count, chien_first, err_bits,
        input  sigma_ready, chien_start, out_valid, out_first, out_last, out_err,
               done, fail, root_count
    );

    modport slave (
        input  sigma_valid, err_count, chien_first, err_bits,
        output sigma_ready, chien_start, out_valid, out_first, out_last, out_err,
               done, fail, root_count
    );
endinterface

// File: rtl/bch_chien_ctrl.sv
// rtl/bch_chien_ctrl.sv - Chien search sequencing controller; BCH_CHIEN_CTRL_ZERO_SKIP_EN skips err_count==0
module bch_chien_ctrl #(
    parameter int DATA_BITS = 16,
    parameter int BITS      = 4,
    parameter int T         = 4,
    parameter int CW        = 4
) (
    input logic             clk,
    input logic             reset,
    bch_chien_ctrl_if.slave bus
);
    localparam int CYCLES = (DATA_BITS + BITS - 1) / BITS;
    localparam int REM    = DATA_BITS % BITS;
    localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [BITS-1:0] ALL_LANES = '1;
    // Earliest lanes sit at the MSB end, so the partial final cycle keeps the top REM lanes.
    localparam logic [BITS-1:0] LAST_MASK = (REM == 0) ? ALL_LANES : (ALL_LANES << (BITS - REM));
    localparam logic [CW-1:0]   SAT       = CW'(T + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_SCAN, S_DONE} state_t;

    state_t          r_state;
    logic [CNT_W-1:0] r_cyc;
    logic [CW-1:0]   r_acc;
    logic [CW-1:0]   r_err_cnt;
    logic            r_chien_start;
    logic            r_out_valid;
    logic            r_out_first;
    logic            r_out_last;
    logic [BITS-1:0] r_out_err;
    logic            r_done;
    logic            r_fail;
    logic [CW-1:0]   r_root_count;

    logic            w_step;
    logic            w_is_last;
    logic [BITS-1:0] w_masked;
    logic [CW-1:0]   w_acc_next;
    int              w_sum;

    always_comb begin
        w_step     = ((r_state == S_WAIT) && bus.chien_first) ||
                     ((r_state == S_SCAN) && !r_out_last);
        w_is_last  = (r_cyc == CNT_W'(CYCLES - 1));
        w_masked   = bus.err_bits & (w_is_last ? LAST_MASK : ALL_LANES);
        w_sum      = int'(r_acc);
        for (int i = 0; i < BITS; i++) begin
            w_sum = w_sum + int'(w_masked[i]);
        end
        w_acc_next = (w_sum > T + 1) ? SAT : CW'(w_sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cyc         <= '0;
            r_acc         <= '0;
            r_err_cnt     <= '0;
            r_chien_start <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_first   <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_err     <= '0;
            r_done        <= 1'b0;
            r_fail        <= 1'b0;
            r_root_count  <= '0;
        end else begin
            r_chien_start <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_first   <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_err     <= '0;
            r_done        <= 1'b0;

            if (w_step) begin
                r_out_valid <= 1'b1;
                r_out_first <= (r_state == S_WAIT);
                r_out_last  <= w_is_last;
                r_out_err   <= w_masked;
                r_acc       <= w_acc_next;
                r_cyc       <= r_cyc + CNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.sigma_valid) begin
                        r_err_cnt <= bus.err_count;
                        r_acc     <= '0;
                        r_cyc     <= '0;
`ifdef BCH_CHIEN_CTRL_ZERO_SKIP_EN
                        if (bus.err_count == '0) begin
                            r_state      <= S_DONE;
                            r_done       <= 1'b1;
                            r_fail       <= 1'b0;
                            r_root_count <= '0;
                        end else begin
                            r_state       <= S_LOAD;
                            r_chien_start <= 1'b1;
                        end
`else
                        r_state       <= S_LOAD;
                        r_chien_start <= 1'b1;
`endif
                    end
                end
                S_LOAD: r_state <= S_WAIT;
                S_WAIT: begin
                    if (bus.chien_first) begin
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // The out_last cycle lets the final accumulation settle before the verdict.
                    if (r_out_last) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_root_count <= r_acc;
                        r_fail       <= (r_acc != r_err_cnt);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.sigma_ready = (r_state == S_IDLE);
    assign bus.chien_start = r_chien_start;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_first   = r_out_first;
    assign bus.out_last    = r_out_last;
    assign bus.out_err     = r_out_err;
    assign bus.done        = r_done;
    assign bus.fail        = r_fail;
    assign bus.root_count  = r_root_count;
endmodule

// File: tb/tb_bch_chien_ctrl.sv
// tb/tb_bch_chien_ctrl.sv - directed table-driven bench for bch_chien_ctrl (16-bit and 14-bit builds)
module tb_bch_chien_ctrl;
    logic       clk;
    logic       reset;
    logic       sigma_valid;
    logic [3:0] err_count;
    logic       chien_first;
    logic [3:0] err_bits;
    logic       use14;

    int n_cmp;
    int n_bad;

    bch_chien_ctrl_if #(.BITS(4), .CW(4)) b16 ();
    bch_chien_ctrl_if #(.BITS(4), .CW(4)) b14 ();

    assign b16.sigma_valid = sigma_valid;
    assign b16.err_count   = err_count;
    assign b16.chien_first = chien_first;
    assign b16.err_bits    = err_bits;
    assign b14.sigma_valid = sigma_valid;
    assign b14.err_count   = err_count;
    assign b14.chien_first = chien_first;
    assign b14.err_bits    = err_bits;

    bch_chien_ctrl #(.DATA_BITS(16), .BITS(4), .T(4), .CW(4)) dut16 (
        .clk(clk), .reset(reset), .bus(b16)
    );
    bch_chien_ctrl #(.DATA_BITS(14), .BITS(4), .T(4), .CW(4)) dut14 (
        .clk(clk), .reset(reset), .bus(b14)
    );

    logic       s_ready, s_start, s_valid, s_first, s_last, s_done, s_fail;
    logic [3:0] s_err, s_root;

    always_comb begin
        if (use14) begin
            s_ready = b14.sigma_ready; s_start = b14.chien_start;
            s_valid = b14.out_valid;   s_first = b14.out_first;
            s_last  = b14.out_last;    s_err   = b14.out_err;
            s_done  = b14.done;        s_fail  = b14.fail;
            s_root  = b14.root_count;
        end else begin
            s_ready = b16.sigma_ready; s_start = b16.chien_start;
            s_valid = b16.out_valid;   s_first = b16.out_first;
            s_last  = b16.out_last;    s_err   = b16.out_err;
            s_done  = b16.done;        s_fail  = b16.fail;
            s_root  = b16.root_count;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       use14;
        logic [3:0] ec;
        logic [3:0] bits [4];
        logic [3:0] exp_err [4];
        logic [3:0] exp_root;
        logic       exp_fail;
    } vec_t;

    vec_t vt [7];

    function automatic vec_t mk(input logic u, input logic [3:0] ec,
                                input logic [3:0] b0, input logic [3:0] b1,
                                input logic [3:0] b2, input logic [3:0] b3,
                                input logic [3:0] e0, input logic [3:0] e1,
                                input logic [3:0] e2, input logic [3:0] e3,
                                input logic [3:0] root, input logic fl);
        vec_t v;
        v.use14 = u; v.ec = ec;
        v.bits[0] = b0; v.bits[1] = b1; v.bits[2] = b2; v.bits[3] = b3;
        v.exp_err[0] = e0; v.exp_err[1] = e1; v.exp_err[2] = e2; v.exp_err[3] = e3;
        v.exp_root = root; v.exp_fail = fl;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        use14       = v.use14;
        err_count   = v.ec;
        sigma_valid = 1'b1;
        #1;
        chk($sformatf("v%0d_ready_idle", idx), 32'(s_ready), 32'd1);
        tick();
        sigma_valid = 1'b0;
        chk($sformatf("v%0d_start", idx), 32'(s_start), 32'd1);
        chk($sformatf("v%0d_ready_busy", idx), 32'(s_ready), 32'd0);
        tick();
        chk($sformatf("v%0d_start_once", idx), 32'(s_start), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chien_first = (i == 0);
            err_bits    = v.bits[i];
            tick();
            chk($sformatf("v%0d_valid%0d", idx, i), 32'(s_valid), 32'd1);
            chk($sformatf("v%0d_err%0d", idx, i), 32'(s_err), 32'(v.exp_err[i]));
            chk($sformatf("v%0d_first%0d", idx, i), 32'(s_first), 32'(i == 0));
            chk($sformatf("v%0d_last%0d", idx, i), 32'(s_last), 32'(i == 3));
        end
        chien_first = 1'b0;
        err_bits    = 4'h0;
        tick();
        chk($sformatf("v%0d_done", idx), 32'(s_done), 32'd1);
        chk($sformatf("v%0d_valid_end", idx), 32'(s_valid), 32'd0);
        chk($sformatf("v%0d_root", idx), 32'(s_root), 32'(v.exp_root));
        chk($sformatf("v%0d_fail", idx), 32'(s_fail), 32'(v.exp_fail));
        tick();
        chk($sformatf("v%0d_done_pulse", idx), 32'(s_done), 32'd0);
        chk($sformatf("v%0d_ready_back", idx), 32'(s_ready), 32'd1);
        chk($sformatf("v%0d_root_held", idx), 32'(s_root), 32'(v.exp_root));
    endtask

    initial begin
        int n_done;
        int hs [$];
        logic p1, p2;

        n_cmp = 0; n_bad = 0;
        vt[0] = mk(0, 4'd2, 4'h0, 4'h4, 4'h0, 4'h1, 4'h0, 4'h4, 4'h0, 4'h1, 4'd2, 1'b0);
        vt[1] = mk(0, 4'd3, 4'h8, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'd1, 1'b1);
        vt[2] = mk(1, 4'd2, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hC, 4'd2, 1'b0);
        vt[3] = mk(0, 4'd4, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'd5, 1'b1);
        vt[4] = mk(0, 4'd4, 4'h9, 4'h0, 4'h6, 4'h0, 4'h9, 4'h0, 4'h6, 4'h0, 4'd4, 1'b0);
        vt[5] = mk(1, 4'd1, 4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'd0, 1'b1);
        vt[6] = mk(0, 4'd1, 4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h3, 4'd2, 1'b1);

        use14 = 1'b0; sigma_valid = 1'b0; err_count = 4'h0;
        chien_first = 1'b0; err_bits = 4'h0;
        reset = 1'b1;
        tick();
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_start", 32'(s_start), 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_done", 32'(s_done), 32'd0);
        chk("rst_fail", 32'(s_fail), 32'd0);
        chk("rst_root", 32'(s_root), 32'd0);
        reset = 1'b0;
        tick();

        chien_first = 1'b1; err_bits = 4'hF;
        tick();
        chk("idle_first_valid", 32'(s_valid), 32'd0);
        tick();
        chk("idle_first_valid2", 32'(s_valid), 32'd0);
        chk("idle_first_ready", 32'(s_ready), 32'd1);
        chk("idle_first_done", 32'(s_done), 32'd0);
        chien_first = 1'b0; err_bits = 4'h0;
        tick();

        for (int k = 0; k < 7; k++) begin
            run_vec(vt[k], k);
        end

        use14 = 1'b0;
`ifdef BCH_CHIEN_CTRL_ZERO_SKIP_EN
        err_count = 4'd0; sigma_valid = 1'b1;
        tick();
        sigma_valid = 1'b0;
        chk("zs_start", 32'(s_start), 32'd0);
        chk("zs_done", 32'(s_done), 32'd1);
        chk("zs_fail", 32'(s_fail), 32'd0);
        chk("zs_root", 32'(s_root), 32'd0);
        chk("zs_ready_busy", 32'(s_ready), 32'd0);
        tick();
        chk("zs_ready_back", 32'(s_ready), 32'd1);
        chk("zs_done_pulse", 32'(s_done), 32'd0);
        chk("zs_valid", 32'(s_valid), 32'd0);
`else
        run_vec(mk(0, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'd0, 1'b0), 7);
`endif

        run_vec(vt[1], 8);
        err_count = 4'd2; sigma_valid = 1'b1;
        tick();
        sigma_valid = 1'b0;
        tick();
        tick();
        chien_first = 1'b1; err_bits = 4'hF;
        tick();
        chien_first = 1'b0;
        tick();
        chk("mid_valid_pre", 32'(s_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_valid", 32'(s_valid), 32'd0);
        chk("mid_err", 32'(s_err), 32'd0);
        chk("mid_fail", 32'(s_fail), 32'd0);
        chk("mid_root", 32'(s_root), 32'd0);
        chk("mid_ready", 32'(s_ready), 32'd1);
        tick();
        reset = 1'b0;
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (s_done) n_done++;
        end
        chk("mid_no_done", 32'(n_done), 32'd0);
        chk("mid_ready_after", 32'(s_ready), 32'd1);
        err_bits = 4'h0;

        err_count = 4'd1; sigma_valid = 1'b1; p1 = 1'b0; p2 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c == 19) sigma_valid = 1'b0;
            chien_first = p2;
            if (sigma_valid && s_ready) hs.push_back(c);
            p2 = p1;
            p1 = s_start;
            tick();
        end
        chien_first = 1'b0;
        chk("b2b_count", 32'(hs.size()), 32'd3);
        if (hs.size() == 3) begin
            chk("b2b_gap0", 32'(hs[1] - hs[0]), 32'd9);
            chk("b2b_gap1", 32'(hs[2] - hs[1]), 32'd9);
        end
        chk("b2b_ready_end", 32'(s_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
